// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and PC step.
`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

package inst_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; flush wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// instruction buffer, with redirect, restart-on-enable and halt on a missing ack.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
    parameter int                         INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                         FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_address,
    input  logic                       imem_ack,
    input  logic [INST_DATA_WIDTH-1:0] imem_data_in,
    output logic                       inst_valid,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc,
    input  logic                       inst_ready,
    output logic                       fetch_done
);
    localparam int AW = INST_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INST_DATA_WIDTH + INST_ADDR_WIDTH;

    fetch_state_t   state_q, state_d;
    logic           fetch_en_q;
    logic [AW-1:0]  pc_q, pc_d;
    logic           inflight_q, inflight_d;
    logic [AW-1:0]  inflight_addr_q;
    logic [EW-1:0]  hold_q, head;
    logic [CW-1:0]  count;
    logic [CW:0]    occupancy;
    logic           rise, redir, flush, resp_ok, push, pop, fail;

    assign rise      = fetch_en & ~fetch_en_q;
    assign redir     = redirect_valid & (state_q != IDLE);
    assign flush     = rise | redir;
    assign resp_ok   = inflight_q & ~flush;
    assign push      = resp_ok & imem_ack;
    assign fail      = resp_ok & ~imem_ack;
    assign pop       = inst_valid & inst_ready;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = FETCH;
            FETCH:   if (flush) state_d = FETCH; else if (fail) state_d = HALT;
            HALT:    if (flush) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == FETCH) && fetch_en && !redirect_valid && !rise
                     && (occupancy < (CW+1)'(FIFO_DEPTH));
        fetch_done = (state_q == HALT);
    end

    // A failed response rewinds the pc and cancels the request issued alongside it.
    always_comb begin
        pc_d = pc_q;
        if (rise)          pc_d = RESET_PC;
        else if (redir)    pc_d = {redirect_pc[AW-1:2], 2'b00};
        else if (fail)     pc_d = inflight_addr_q;
        else if (imem_req) pc_d = pc_q + AW'(PC_INC);
        inflight_d = imem_req & ~fail;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_en_q <= 1'b0;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            fetch_en_q <= fetch_en;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            if (inst_valid) hold_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) inflight_addr_q <= pc_q;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i ({imem_data_in, inflight_addr_q}),
        .pop_i       (pop),
        .flush_i     (flush),
        .count_o     (count),
        .head_o      (head)
    );

    assign imem_address         = pc_q;
    assign inst_valid           = (count != '0);
    assign {inst_data, inst_pc} = inst_valid ? head : hold_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a queue-based model checked every cycle plus
// literal expectations for the loaded-program, backpressure, redirect and reset scenarios.
module tb_inst_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    typedef struct packed { logic [31:0] d; logic [31:0] a; } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en, redirect_valid, inst_ready, imem_ack;
    logic [31:0] redirect_pc, imem_data_in;
    logic        imem_req, inst_valid, fetch_done;
    logic [31:0] imem_address, inst_data, inst_pc;

    always #5 clk = ~clk;

    inst_fetch #(
        .INST_ADDR_WIDTH (32),
        .INST_DATA_WIDTH (32),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_address   (imem_address),
        .imem_ack       (imem_ack),
        .imem_data_in   (imem_data_in),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_done     (fetch_done)
    );

    int checks = 0;
    int failures = 0;

    ent_t        m_buf[$];
    ent_t        pops[$];
    logic [31:0] reqs[$];
    int          m_mode;
    logic [31:0] m_pc, m_pend_addr;
    bit          m_pend, m_prev_en, model_on;
    ent_t        m_last;
    logic [31:0] mem_limit, req_addr;
    bit          req_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00500093;
            32'h4:   return 32'h00100113;
            32'h8:   return 32'h002081B3;
            default: return 32'hC0DE0000 ^ a;
        endcase
    endfunction

    function automatic ent_t pop_at(input int i);
        if (i < pops.size()) return pops[i];
        return 'x;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < reqs.size()) return reqs[i];
        return 'x;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_mode    = 0;
        m_pc      = RPC;
        m_pend    = 1'b0;
        m_pend_addr = '0;
        m_prev_en = 1'b0;
        m_last    = '0;
    endtask

    // Modes: 0 idle, 1 fetching, 2 halted. Evaluated with this cycle's inputs.
    task automatic model_step();
        bit          rise, redir, exp_req, exp_valid, ok;
        ent_t        head;
        logic [31:0] old_pc;
        rise      = fetch_en && !m_prev_en;
        redir     = redirect_valid && (m_mode != 0);
        exp_req   = (m_mode == 1) && fetch_en && !redirect_valid && !rise
                    && (m_buf.size() + int'(m_pend) < DEPTH);
        exp_valid = (m_buf.size() > 0);
        head      = exp_valid ? m_buf[0] : m_last;
        chk("req",   64'(imem_req),     64'(exp_req));
        chk("addr",  64'(imem_address), 64'(m_pc));
        chk("valid", 64'(inst_valid),   64'(exp_valid));
        chk("data",  64'(inst_data),    64'(head.d));
        chk("pc",    64'(inst_pc),      64'(head.a));
        chk("done",  64'(fetch_done),   64'(m_mode == 2));
        m_last = head;
        old_pc = m_pc;
        ok     = m_pend && !rise && !redir;
        if (rise) begin
            m_buf.delete();
            m_pc   = RPC;
            m_mode = 1;
        end else if (redir) begin
            m_buf.delete();
            m_pc   = redirect_pc & ~32'h3;
            m_mode = 1;
        end else begin
            if (exp_valid && inst_ready) void'(m_buf.pop_front());
            if (ok && imem_ack) m_buf.push_back({imem_data_in, m_pend_addr});
            if (ok && !imem_ack) begin
                m_pc   = m_pend_addr;
                m_mode = 2;
            end else if (exp_req) begin
                m_pc = m_pc + 32'd4;
            end
        end
        m_pend      = exp_req && !(ok && !imem_ack);
        m_pend_addr = old_pc;
        m_prev_en   = fetch_en;
    endtask

    // One clock: check at the falling edge, then answer the memory request after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (model_on) model_step();
        if (inst_valid && inst_ready) pops.push_back({inst_data, inst_pc});
        if (imem_req) reqs.push_back(imem_address);
        req_prev = imem_req;
        req_addr = imem_address;
        @(posedge clk);
        #1;
        imem_ack     = req_prev && (req_addr < mem_limit);
        imem_data_in = word_at(req_addr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   64'(imem_req),     64'(0));
        chk({tag, "_addr"},  64'(imem_address), 64'(RPC));
        chk({tag, "_valid"}, 64'(inst_valid),   64'(0));
        chk({tag, "_data"},  64'(inst_data),    64'(0));
        chk({tag, "_pc"},    64'(inst_pc),      64'(0));
        chk({tag, "_done"},  64'(fetch_done),   64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ent_t e;
        reset_n = 1'b1;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        imem_ack = 1'b0; imem_data_in = '0;
        mem_limit = 32'hC; req_prev = 1'b0; req_addr = '0; model_on = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;

        // Three-word program, the fourth fetch is not acknowledged.
        inst_ready = 1'b1; fetch_en = 1'b1;
        pops.delete(); reqs.delete();
        repeat (12) cycle();
        chk("a_npop", 64'(pops.size()), 64'(3));
        chk("a_w0", pop_at(0), {32'h00500093, 32'h0});
        chk("a_w1", pop_at(1), {32'h00100113, 32'h4});
        chk("a_w2", pop_at(2), {32'h002081B3, 32'h8});
        chk("a_req3", 64'(req_at(3)), 64'h0C);
        chk("a_done", 64'(fetch_done), 64'(1));
        chk("a_noreq", 64'(imem_req), 64'(0));
        chk("a_haltaddr", 64'(imem_address), 64'h0C);

        // Redirect out of HALT.
        redirect_valid = 1'b1; redirect_pc = 32'h4; pops.delete();
        cycle();
        redirect_valid = 1'b0;
        chk("b_done", 64'(fetch_done), 64'(0));
        chk("b_addr", 64'(imem_address), 64'h4);
        repeat (8) cycle();
        chk("b_w0", pop_at(0), {32'h00100113, 32'h4});
        chk("b_w1", pop_at(1), {32'h002081B3, 32'h8});
        chk("b_halt", 64'(fetch_done), 64'(1));

        // Backpressure with memory always acknowledging.
        mem_limit = 32'hFFFF_FFFF;
        fetch_en = 1'b0;
        cycle();
        fetch_en = 1'b1; inst_ready = 1'b0;
        pops.delete(); reqs.delete();
        repeat (12) cycle();
        chk("c_nreq", 64'(reqs.size()), 64'(4));
        chk("c_valid", 64'(inst_valid), 64'(1));
        chk("c_head", 64'(inst_pc), 64'h0);
        chk("c_noreq", 64'(imem_req), 64'(0));
        inst_ready = 1'b1; pops.delete();
        repeat (6) cycle();
        for (int i = 0; i < 6; i++) begin
            e = pop_at(i);
            chk($sformatf("c_pc%0d", i), 64'(e.a), 64'(4 * i));
        end

        // Redirect while entries are buffered and a response is in flight.
        inst_ready = 1'b0;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        cycle();
        redirect_valid = 1'b0;
        chk("d_addr", 64'(imem_address), 64'h20);
        chk("d_valid", 64'(inst_valid), 64'(0));
        inst_ready = 1'b1; pops.delete();
        repeat (4) cycle();
        chk("d_w0", pop_at(0), {32'hC0DE0020, 32'h20});

        // fetch_en low-high toggle restarts at RESET_PC.
        fetch_en = 1'b0;
        cycle();
        fetch_en = 1'b1;
        cycle();
        chk("e_valid", 64'(inst_valid), 64'(0));
        chk("e_addr", 64'(imem_address), 64'(RPC));
        pops.delete();
        repeat (4) cycle();
        chk("e_w0", pop_at(0), {32'h00500093, 32'h0});

        // Asynchronous reset with a request outstanding; the late ack is ignored.
        for (int i = 0; i < 10 && !req_prev; i++) cycle();
        chk("f_pending", 64'(req_prev), 64'(1));
        model_on = 1'b0;
        reset_n  = 1'b0;
        fetch_en = 1'b0;
        #1 chk_reset_outputs("f_rst");
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        model_on = 1'b1;
        imem_ack = 1'b1; imem_data_in = 32'hDEADBEEF; req_prev = 1'b0;
        repeat (4) cycle();
        chk("f_valid", 64'(inst_valid), 64'(0));
        chk("f_data", 64'(inst_data), 64'(0));
        chk("f_done", 64'(fetch_done), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
